// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the register-write trace buffer: FSM state
// encodings, fixed field widths and the packed entry width helper.
package wb_trace_buffer_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Width of one stored entry {cycle, reg, data}
    function automatic int entry_w(input int cyc_w);
        return cyc_w + REG_W + DATA_W;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Drain-side bus of the trace buffer: valid/ready handshake plus the head
// entry fields. The buffer is the master, the consumer is the slave.
interface wb_trace_buffer_if #(parameter int CYC_W = 10);

    logic             trace_valid;
    logic             trace_ready;
    logic [CYC_W-1:0] trace_cycle;
    logic [4:0]       trace_reg;
    logic [31:0]      trace_data;

    modport master (
        output trace_valid, trace_cycle, trace_reg, trace_data,
        input  trace_ready
    );

    modport slave (
        input  trace_valid, trace_cycle, trace_reg, trace_data,
        output trace_ready
    );

endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// Generic synchronous first-word-fall-through FIFO (module wb_trace_fifo).
// The head entry is presented combinationally whenever the FIFO is not empty.
// Storage is not reset; only pointers and count are.
module wb_trace_fifo #(
    parameter int WIDTH = 47,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok, push_ok;

    // Qualify requests and advance pointers/count (pointers wrap modulo DEPTH)
    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Register-write trace buffer: time-stamps qualifying regfile writes and
// queues {cycle, reg, data} in a FWFT FIFO for a downstream drain.
// Optional feature macro: WB_TRACE_DROP_CNT_EN adds the trace_drops counter port.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CYC_W = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    trace_start,
    input  logic                    trace_stop,
    input  logic                    ctrl_writeEnable,
    input  logic [4:0]              ctrl_writeReg,
    input  logic [31:0]             data_writeReg,
    wb_trace_buffer_if.master       trace_bus,
    output logic                    trace_overflow,
    output logic                    trace_done
`ifdef WB_TRACE_DROP_CNT_EN
    ,
    output logic [15:0]             trace_drops
`endif
);

    localparam int EW    = entry_w(CYC_W);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             overflow_q, overflow_d;
    logic             start_go, wr_event, push, pop, drop;
    logic             fifo_empty, fifo_full;
    logic [CNT_W-1:0] fifo_count;
    logic [EW-1:0]    head;

    // Event qualification and FIFO handshake; r0 writes are never traced
    always_comb begin
        start_go = trace_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        wr_event = (state_q == ST_RUN) && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
        pop      = !fifo_empty && trace_bus.trace_ready;
        push     = wr_event && (!fifo_full || pop);
        drop     = wr_event && fifo_full && !pop;
    end

    // FSM next state; DRAIN finishes on the edge that leaves the FIFO empty
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_go) state_d = ST_RUN;
            ST_RUN:   if (trace_stop) state_d = ST_DRAIN;
            ST_DRAIN: if (fifo_empty || ((fifo_count == CNT_W'(1)) && pop)) state_d = ST_DONE;
            ST_DONE:  if (start_go) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Cycle stamp and sticky overflow; both restart on an accepted start
    always_comb begin
        cyc_d      = cyc_q;
        overflow_d = overflow_q;
        if (start_go) begin
            cyc_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (state_q == ST_RUN) cyc_d = cyc_q + CYC_W'(1);
            if (drop) overflow_d = 1'b1;
        end
    end

    // Control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef WB_TRACE_DROP_CNT_EN
    logic [15:0] drops_q, drops_d;

    // Saturating count of dropped events
    always_comb begin
        drops_d = drops_q;
        if (start_go) drops_d = '0;
        else if (drop && (drops_q != 16'hFFFF)) drops_d = drops_q + 16'd1;
    end

    // Drop counter register
    always_ff @(posedge clock) begin
        if (reset) drops_q <= '0;
        else       drops_q <= drops_d;
    end

    assign trace_drops = drops_q;
`endif

    wb_trace_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .push    (push),
        .wr_data ({cyc_q, ctrl_writeReg, data_writeReg}),
        .pop     (pop),
        .rd_data (head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // Head fields are forced to zero while nothing is valid
    always_comb begin
        trace_bus.trace_valid = !fifo_empty;
        trace_bus.trace_cycle = fifo_empty ? '0 : head[EW-1 -: CYC_W];
        trace_bus.trace_reg   = fifo_empty ? '0 : head[DATA_W +: REG_W];
        trace_bus.trace_data  = fifo_empty ? '0 : head[DATA_W-1:0];
    end

    assign trace_overflow = overflow_q;
    assign trace_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with a queue scoreboard of expected
// entries (DEPTH=16, CYC_W=10). Build with WB_TRACE_DROP_CNT_EN to cover trace_drops.
module tb_wb_trace_buffer;

    localparam int DEPTH = 16;
    localparam int CYC_W = 10;

    typedef struct packed {
        logic [CYC_W-1:0] cyc;
        logic [4:0]       rg;
        logic [31:0]      dat;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        trace_start;
    logic        trace_stop;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        overflow;
    logic        done;
`ifdef WB_TRACE_DROP_CNT_EN
    logic [15:0] drops;
`endif

    wb_trace_buffer_if #(.CYC_W(CYC_W)) bus ();

    wb_trace_buffer #(
        .DEPTH (DEPTH),
        .CYC_W (CYC_W)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .trace_start      (trace_start),
        .trace_stop       (trace_stop),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wreg),
        .data_writeReg    (wdata),
        .trace_bus        (bus),
        .trace_overflow   (overflow),
        .trace_done       (done)
`ifdef WB_TRACE_DROP_CNT_EN
        ,
        .trace_drops      (drops)
`endif
    );

    always #5 clock = ~clock;

    ent_t             sb[$];
    int               errors = 0;
    int               checks = 0;
    bit               mrun   = 1'b0;
    logic [CYC_W-1:0] mcyc   = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; the expected stamp advances for every edge spent in RUN
    task automatic step();
        @(posedge clock);
        if (mrun) mcyc = mcyc + CYC_W'(1);
        #1;
    endtask

    task automatic do_start();
        trace_start = 1'b1;
        @(posedge clock);
        mrun = 1'b1;
        mcyc = '0;
        #1;
        trace_start = 1'b0;
    endtask

    task automatic do_stop();
        trace_stop = 1'b1;
        @(posedge clock);
        mrun = 1'b0;
        #1;
        trace_stop = 1'b0;
    endtask

    // One regfile write; expected entry queued only if the buffer can take it
    task automatic ev(input logic [4:0] r, input logic [31:0] d);
        we    = 1'b1;
        wreg  = r;
        wdata = d;
        if (mrun && (r != 5'd0) && (sb.size() < DEPTH)) sb.push_back('{mcyc, r, d});
        step();
        we    = 1'b0;
        wreg  = '0;
        wdata = '0;
    endtask

    // Wait (bounded) for a head entry, compare it with the scoreboard, pop it
    task automatic drain_one(input string tag);
        int   n;
        ent_t e;
        n = 0;
        while (!bus.trace_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 64'(bus.trace_valid), 64'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_cyc"},  64'(bus.trace_cycle), 64'(e.cyc));
            chk({tag, "_reg"},  64'(bus.trace_reg),   64'(e.rg));
            chk({tag, "_data"}, 64'(bus.trace_data),  64'(e.dat));
        end
        bus.trace_ready = 1'b1;
        step();
        bus.trace_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        reset = 1'b1; trace_start = 1'b0; trace_stop = 1'b0;
        we = 1'b0; wreg = '0; wdata = '0; bus.trace_ready = 1'b0;
        step();
        step();
        chk("rst_valid",    64'(bus.trace_valid), 64'd0);
        chk("rst_cycle",    64'(bus.trace_cycle), 64'd0);
        chk("rst_reg",      64'(bus.trace_reg),   64'd0);
        chk("rst_data",     64'(bus.trace_data),  64'd0);
        chk("rst_overflow", 64'(overflow),        64'd0);
        chk("rst_done",     64'(done),            64'd0);
        reset = 1'b0;
        step();

        // 1: capture at RUN cycle 3, r0 write ignored
        do_start();
        step(); step(); step();
        ev(5'd5, 32'd7);
        chk("t1_latency_valid", 64'(bus.trace_valid), 64'd1);
        chk("t1_stamp", 64'(bus.trace_cycle), 64'd3);
        ev(5'd0, 32'd9);
        drain_one("t1");
        chk("t1_r0_not_captured", 64'(bus.trace_valid), 64'd0);

        // 2: 17 events into a 16-deep FIFO with no drain
        for (int i = 0; i < 17; i++) ev(5'(1 + i), 32'hA000_0000 + 32'(i));
        chk("t2_overflow", 64'(overflow), 64'd1);
`ifdef WB_TRACE_DROP_CNT_EN
        chk("t2_drops", 64'(drops), 64'd1);
`endif
        for (int i = 0; i < 16; i++) drain_one("t2");
        chk("t2_empty", 64'(bus.trace_valid), 64'd0);

        // 3: stop -> done, restart clears overflow, then full + pop + event
        do_stop();
        step();
        chk("t3_done_empty_drain", 64'(done), 64'd1);
        do_start();
        chk("t3_overflow_cleared", 64'(overflow), 64'd0);
        chk("t3_done_cleared", 64'(done), 64'd0);
        for (int i = 0; i < 16; i++) ev(5'(1 + i), 32'hB000_0000 + 32'(i));
        e = sb.pop_front();
        chk("t3_head_cyc",  64'(bus.trace_cycle), 64'(e.cyc));
        chk("t3_head_data", 64'(bus.trace_data),  64'(e.dat));
        sb.push_back('{mcyc, 5'd20, 32'h0000_C0DE});
        we = 1'b1; wreg = 5'd20; wdata = 32'h0000_C0DE; bus.trace_ready = 1'b1;
        step();
        we = 1'b0; wreg = '0; wdata = '0; bus.trace_ready = 1'b0;
        chk("t3_overflow_stays0", 64'(overflow), 64'd0);
        for (int i = 0; i < 16; i++) drain_one("t3");
        chk("t3_count16_empty", 64'(bus.trace_valid), 64'd0);

        // 4: stop with 3 queued, DRAIN ignores events, done after last pop
        ev(5'd1, 32'h11); ev(5'd2, 32'h22); ev(5'd3, 32'h33);
        do_stop();
        chk("t4_done_after_stop", 64'(done), 64'd0);
        we = 1'b1; wreg = 5'd9; wdata = 32'h0000_DEAD;
        drain_one("t4a");
        we = 1'b0; wreg = '0; wdata = '0;
        chk("t4_done_after_pop1", 64'(done), 64'd0);
        drain_one("t4b");
        chk("t4_done_after_pop2", 64'(done), 64'd0);
        drain_one("t4c");
        step();
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_valid", 64'(bus.trace_valid), 64'd0);

        // 5: cycle stamp wraps at 2^CYC_W
        do_start();
        for (int i = 0; i < 1025; i++) step();
        ev(5'd7, 32'h5555_5555);
        for (int i = 0; i < 4; i++) step();
        chk("t5_wrap_cycle", 64'(bus.trace_cycle), 64'd1);
        drain_one("t5");

        // 6: reset mid-RUN with entries queued and overflow set
        for (int i = 0; i < 17; i++) ev(5'(1 + i), 32'hC000_0000 + 32'(i));
        chk("t6_pre_overflow", 64'(overflow), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        mrun = 1'b0;
        chk("t6_valid",    64'(bus.trace_valid), 64'd0);
        chk("t6_overflow", 64'(overflow),        64'd0);
        chk("t6_cycle",    64'(bus.trace_cycle), 64'd0);
        chk("t6_data",     64'(bus.trace_data),  64'd0);
        chk("t6_done",     64'(done),            64'd0);
        ev(5'd3, 32'h1);
        step();
        chk("t6_idle_no_capture", 64'(bus.trace_valid), 64'd0);
        trace_start = 1'b1; trace_stop = 1'b1;
        @(posedge clock);
        mrun = 1'b1;
        mcyc = '0;
        #1;
        trace_start = 1'b0; trace_stop = 1'b0;
        ev(5'd4, 32'h44);
        drain_one("t6_start_wins");
        chk("t6_final_empty", 64'(bus.trace_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
